// File: rtl/vgpr_wr_burst_sequencer.sv
// Write-side initiator for the banked VGPR file: splits multi-dword bursts into wr1 beats
// and registers ALU single writes onto wr0. Optional hold-on-overlap via VGPR_WR_COLLISION_CHECK_EN.
module vgpr_wr_burst_sequencer #(
   parameter int unsigned MAX_DW = 16,
   parameter int unsigned AW     = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [AW-1:0]         req_addr,
   input  logic [4:0]            req_len,
   input  logic [32*MAX_DW-1:0]  req_data,
   input  logic                  alu_wr_en,
   input  logic [AW-1:0]         alu_wr_addr,
   input  logic [31:0]           alu_wr_data,
   output logic                  wr0_en,
   output logic [AW-1:0]         wr0_addr,
   output logic [31:0]           wr0_data,
   output logic [3:0]            wr1_en,
   output logic [AW-1:0]         wr1_addr,
   output logic [127:0]          wr1_data,
   output logic                  burst_done,
   output logic                  wr_collision
);

   localparam int unsigned BW = 32 * MAX_DW;

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rem_addr_q, rem_addr_d;
   logic [4:0]      rem_len_q, rem_len_d;
   logic [BW-1:0]   buf_q, buf_d;
   logic            zdone_q, zdone_d;
   logic            wr0_en_q;
   logic [AW-1:0]   wr0_addr_q;
   logic [31:0]     wr0_data_q;
   logic [2:0]      adv;
   logic            hold;

   assign adv = (rem_len_q >= 5'd4) ? 3'd4 :
                (rem_len_q >= 5'd2) ? 3'd2 : 3'd1;

`ifdef VGPR_WR_COLLISION_CHECK_EN
   // Offset of the pending ALU write from the beat base; modular subtraction handles wrap.
   logic [AW-1:0] ovl_off;
   assign ovl_off = wr0_addr_q - rem_addr_q;
   assign hold    = (state_q == BURST) && wr0_en_q && (ovl_off < AW'(adv));
`else
   assign hold    = 1'b0;
`endif

   assign wr_collision = hold;
   assign wr0_en       = wr0_en_q;
   assign wr0_addr     = wr0_addr_q;
   assign wr0_data     = wr0_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rem_addr_q <= '0;
         rem_len_q  <= '0;
         buf_q      <= '0;
         zdone_q    <= 1'b0;
         wr0_en_q   <= 1'b0;
         wr0_addr_q <= '0;
         wr0_data_q <= '0;
      end else begin
         state_q    <= state_d;
         rem_addr_q <= rem_addr_d;
         rem_len_q  <= rem_len_d;
         buf_q      <= buf_d;
         zdone_q    <= zdone_d;
         wr0_en_q   <= alu_wr_en;
         wr0_addr_q <= alu_wr_addr;
         wr0_data_q <= alu_wr_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      rem_addr_d = rem_addr_q;
      rem_len_d  = rem_len_q;
      buf_d      = buf_q;
      zdone_d    = 1'b0;
      req_ready  = 1'b0;
      wr1_en     = '0;
      wr1_addr   = '0;
      wr1_data   = '0;
      burst_done = zdone_q;
      case (state_q)
         IDLE: begin
            req_ready = ~rst;
            if (req_valid) begin
               if (req_len != 5'd0) begin
                  rem_addr_d = req_addr;
                  rem_len_d  = req_len;
                  buf_d      = req_data;
                  state_d    = BURST;
               end else begin
                  zdone_d = 1'b1;
               end
            end
         end
         BURST: begin
            if (!hold) begin
               wr1_addr = rem_addr_q;
               case (adv)
                  3'd4: begin
                     wr1_en   = 4'b1111;
                     wr1_data = buf_q[127:0];
                  end
                  3'd2: begin
                     wr1_en   = 4'b0011;
                     wr1_data = {64'b0, buf_q[63:0]};
                  end
                  default: begin
                     wr1_en   = 4'b0001;
                     wr1_data = {96'b0, buf_q[31:0]};
                  end
               endcase
               rem_addr_d = rem_addr_q + AW'(adv);
               rem_len_d  = rem_len_q - 5'(adv);
               buf_d      = buf_q >> {adv, 5'b0};
               if (rem_len_q == 5'(adv)) begin
                  burst_done = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_vgpr_wr_burst_sequencer.sv
// Directed self-checking bench for vgpr_wr_burst_sequencer; expectations follow the
// VGPR_WR_COLLISION_CHECK_EN setting of the build.
module tb_vgpr_wr_burst_sequencer;

   localparam int unsigned MAX_DW = 16;
   localparam int unsigned AW     = 10;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  req_valid;
   logic                  req_ready;
   logic [AW-1:0]         req_addr;
   logic [4:0]            req_len;
   logic [32*MAX_DW-1:0]  req_data;
   logic                  alu_wr_en;
   logic [AW-1:0]         alu_wr_addr;
   logic [31:0]           alu_wr_data;
   logic                  wr0_en;
   logic [AW-1:0]         wr0_addr;
   logic [31:0]           wr0_data;
   logic [3:0]            wr1_en;
   logic [AW-1:0]         wr1_addr;
   logic [127:0]          wr1_data;
   logic                  burst_done;
   logic                  wr_collision;

   int n_checks = 0;
   int n_errors = 0;

   vgpr_wr_burst_sequencer #(.MAX_DW(MAX_DW), .AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_len      (req_len),
      .req_data     (req_data),
      .alu_wr_en    (alu_wr_en),
      .alu_wr_addr  (alu_wr_addr),
      .alu_wr_data  (alu_wr_data),
      .wr0_en       (wr0_en),
      .wr0_addr     (wr0_addr),
      .wr0_data     (wr0_data),
      .wr1_en       (wr1_en),
      .wr1_addr     (wr1_addr),
      .wr1_data     (wr1_data),
      .burst_done   (burst_done),
      .wr_collision (wr_collision)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Samples on the falling edge and checks the wr1 side of one cycle.
   task automatic beat(input string tag, input logic [3:0] en, input logic [AW-1:0] addr,
                       input logic [127:0] data, input logic done);
      @(negedge clk);
      check({tag, ".en"},   128'(wr1_en),     128'(en));
      check({tag, ".addr"}, 128'(wr1_addr),   128'(addr));
      check({tag, ".data"}, wr1_data,         data);
      check({tag, ".done"}, 128'(burst_done), 128'(done));
      check({tag, ".rdy"},  128'(req_ready),  128'(0));
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      check({tag, ".rdy"},  128'(req_ready),  128'(1));
      check({tag, ".en"},   128'(wr1_en),     128'(0));
      check({tag, ".done"}, 128'(burst_done), 128'(0));
   endtask

   // Called right after a falling edge while IDLE; returns just after the accepting edge.
   task automatic send(input logic [AW-1:0] a, input logic [4:0] l, input logic [32*MAX_DW-1:0] d);
      req_valid = 1'b1;
      req_addr  = a;
      req_len   = l;
      req_data  = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      alu_wr_en = 1'b0;
   endtask

   logic [32*MAX_DW-1:0] d;

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_data = '0;
      alu_wr_en = 1'b0; alu_wr_addr = '0; alu_wr_data = '0;

      // Reset state
      @(negedge clk);
      check("rst.rdy",  128'(req_ready),  128'(0));
      check("rst.wr1",  128'(wr1_en),     128'(0));
      check("rst.wr0",  128'(wr0_en),     128'(0));
      check("rst.done", 128'(burst_done), 128'(0));
      check("rst.col",  128'(wr_collision), 128'(0));
      rst = 1'b0;
      idle_chk("post_rst");

      // Aligned 16-dword burst, dword k = k+1
      for (int k = 0; k < 16; k++) d[32*k +: 32] = 32'(k + 1);
      send(10'h100, 5'd16, d);
      beat("al0", 4'b1111, 10'h100, 128'h00000004_00000003_00000002_00000001, 1'b0);
      beat("al1", 4'b1111, 10'h104, 128'h00000008_00000007_00000006_00000005, 1'b0);
      beat("al2", 4'b1111, 10'h108, 128'h0000000C_0000000B_0000000A_00000009, 1'b0);
      beat("al3", 4'b1111, 10'h10C, 128'h00000010_0000000F_0000000E_0000000D, 1'b1);
      idle_chk("al_end");

      // Unaligned len=7 wrapping the address space; dwords beyond len are junk
      for (int k = 0; k < 16; k++) d[32*k +: 32] = (k < 7) ? 32'(32'hA0 + k) : 32'hDEADBEEF;
      send(10'h3FD, 5'd7, d);
      beat("un0", 4'b1111, 10'h3FD, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0);
      beat("un1", 4'b0011, 10'h001, 128'h00000000_00000000_000000A5_000000A4, 1'b0);
      beat("un2", 4'b0001, 10'h003, 128'h00000000_00000000_00000000_000000A6, 1'b1);
      idle_chk("un_end");

      // len=0: no beat, done pulse the cycle after acceptance
      send(10'h010, 5'd0, d);
      @(negedge clk);
      check("z.en",   128'(wr1_en),     128'(0));
      check("z.done", 128'(burst_done), 128'(1));
      check("z.rdy",  128'(req_ready),  128'(1));
      idle_chk("z_end");

      // len=1
      d = '0; d[31:0] = 32'h12345678;
      send(10'h050, 5'd1, d);
      beat("one", 4'b0001, 10'h050, 128'h00000000_00000000_00000000_12345678, 1'b1);
      idle_chk("one_end");

      // ALU write concurrent with an 8-dword burst at 0x200
      for (int k = 0; k < 16; k++) d[32*k +: 32] = 32'(32'h200 + k);
      alu_wr_en = 1'b1; alu_wr_addr = 10'h020; alu_wr_data = 32'h55AA;
      send(10'h200, 5'd8, d);
      beat("cc0", 4'b1111, 10'h200, 128'h00000203_00000202_00000201_00000200, 1'b0);
      check("cc.wr0en",   128'(wr0_en),   128'(1));
      check("cc.wr0addr", 128'(wr0_addr), 128'(10'h020));
      check("cc.wr0data", 128'(wr0_data), 128'(32'h55AA));
      beat("cc1", 4'b1111, 10'h204, 128'h00000207_00000206_00000205_00000204, 1'b1);
      check("cc.wr0off",  128'(wr0_en),   128'(0));
      idle_chk("cc_end");

      // Overlapping ALU write to 0x042 during a len=4 beat at 0x040
      for (int k = 0; k < 16; k++) d[32*k +: 32] = 32'(32'h10 + k);
      alu_wr_en = 1'b1; alu_wr_addr = 10'h042; alu_wr_data = 32'hCAFE;
      send(10'h040, 5'd4, d);
`ifdef VGPR_WR_COLLISION_CHECK_EN
      beat("col_hold", 4'b0000, 10'h000, 128'h0, 1'b0);
      check("col.flag", 128'(wr_collision), 128'(1));
      check("col.wr0",  128'(wr0_addr),     128'(10'h042));
      beat("col_retry", 4'b1111, 10'h040, 128'h00000013_00000012_00000011_00000010, 1'b1);
      check("col.flag2", 128'(wr_collision), 128'(0));
`else
      beat("col_pass", 4'b1111, 10'h040, 128'h00000013_00000012_00000011_00000010, 1'b1);
      check("col.flag", 128'(wr_collision), 128'(0));
      check("col.wr0",  128'(wr0_en),       128'(1));
`endif
      idle_chk("col_end");

      // Reset during the second beat of a 16-dword burst
      for (int k = 0; k < 16; k++) d[32*k +: 32] = 32'(k);
      send(10'h000, 5'd16, d);
      beat("rb0", 4'b1111, 10'h000, 128'h00000003_00000002_00000001_00000000, 1'b0);
      alu_wr_en = 1'b1; alu_wr_addr = 10'h300; alu_wr_data = 32'h1;
      beat("rb1", 4'b1111, 10'h004, 128'h00000007_00000006_00000005_00000004, 1'b0);
      check("rb.wr0", 128'(wr0_en), 128'(1));
      alu_wr_en = 1'b0;
      rst = 1'b1;
      #1;
      check("ra.wr1en",   128'(wr1_en),     128'(0));
      check("ra.wr1addr", 128'(wr1_addr),   128'(0));
      check("ra.wr1data", wr1_data,         128'h0);
      check("ra.wr0",     128'(wr0_en),     128'(0));
      check("ra.wr0addr", 128'(wr0_addr),   128'(0));
      check("ra.rdy",     128'(req_ready),  128'(0));
      check("ra.done",    128'(burst_done), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) idle_chk("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vgpr_wr_burst_sequencer.md
Name: vgpr_wr_burst_sequencer

Overview:
- Write-side initiator for the 1024x32b banked register file (2 write ports: wr0 = 32-bit single dword; wr1 = up to 128-bit with 4-bit enable, unaligned allowed).
- Takes multi-dword writeback bursts (1..16 dwords, e.g. LSU loads) and splits them into legal wr1 beats (enable 0001/0011/1111).
- Forwards ALU single-dword writebacks onto wr0 through one register stage.
- Sits between the LSU/ALU writeback paths and the register file.

Parameters:
- MAX_DW, 16, max dwords per burst; req_data width = 32*MAX_DW.
- AW, 10, register file address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- req_valid  in  1  burst request valid
- req_ready  out  1  sequencer can accept a burst
- req_addr  in  AW  first dword address (any alignment)
- req_len  in  5  dword count; 1..16 legal, 0 = no-op
- req_data  in  32*MAX_DW  dword k at bits [32k+31:32k]
- alu_wr_en  in  1  ALU single write strobe
- alu_wr_addr  in  AW  ALU write address
- alu_wr_data  in  32  ALU write data
- wr0_en  out  1  to register file wr0
- wr0_addr  out  AW
- wr0_data  out  32
- wr1_en  out  4  to register file wr1; only 0000/0001/0011/1111
- wr1_addr  out  AW
- wr1_data  out  128
- burst_done  out  1  one-cycle pulse on the cycle the last beat of a burst is driven
- wr_collision  out  1  one-cycle pulse when a beat is held for a wr0 overlap

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. While rst is high, all outputs are 0 and state is IDLE. Asserting rst mid-burst aborts the burst; the remaining dwords are dropped.
- wr0 path: wr0_en/addr/data are registered copies of alu_wr_en/addr/data, so latency is 1 cycle. It is independent of the FSM and never stalls.
- FSM states:
  - IDLE: req_ready=1.
    - req_valid & req_len!=0: latch addr, len and data into rem_addr, rem_len and a shift buffer; go to BURST.
    - req_valid & req_len==0: accept, pulse burst_done next cycle, stay IDLE.
  - BURST: req_ready=0. Each cycle drive one beat:
    - rem_len>=4: wr1_en=1111, data = buffer[127:0], advance 4 dwords.
    - rem_len 2..3: wr1_en=0011, data = {64'b0, buffer[63:0]}, advance 2.
    - rem_len 1: wr1_en=0001, data = {96'b0, buffer[31:0]}, advance 1.
    - Per beat: wr1_addr = rem_addr; rem_addr += advance (mod 2^AW, wraps 1023->0); buffer shifts right by 32*advance; rem_len -= advance.
    - When rem_len reaches 0: pulse burst_done with that beat, return to IDLE. req_ready=1 the following cycle.
  - Outside BURST, wr1_en=0000 and wr1_addr/data=0.
- Timing:
  - First beat is driven the cycle after acceptance.
  - Burst length L takes floor(L/4) + (L%4>=2) + (L%2) beats.
  - No back-to-back acceptance: minimum 1 IDLE cycle between bursts.
- Simultaneous ALU write and burst beats are both driven; the port split makes this legal when addresses differ.

Optional Feature:
- Macro: VGPR_WR_COLLISION_CHECK_EN.
- Defined:
  - In BURST, if registered wr0_en=1 and wr0_addr lies in [rem_addr, rem_addr+advance-1] (mod 2^AW), the beat is held.
  - Held beat: wr1_en=0000, state/counters unchanged, wr_collision=1. The beat retries next cycle, so the ALU write lands first and the burst value wins.
  - A held beat never asserts burst_done.
- Undefined: no comparison; wr_collision tied 0; overlapping writes go to the register file in the same cycle (result undefined there).

Test Plan:
- Aligned 16-dword burst: addr=0x100, len=16, data k=k+1 -> 4 beats of 1111 at 0x100/0x104/0x108/0x10C with data {4,3,2,1}... ; burst_done on 4th beat; req_ready back 1 cycle later.
- Unaligned len=7 at addr=0x3FD -> beats 1111@0x3FD, 0011@0x001, 0001@0x003 (address wrap); unused wr1_data bits = 0.
- len=0 and len=1 -> len 0: no wr1 beat, burst_done 1 cycle after accept; len 1: single 0001 beat.
- ALU write 0x55AA at addr 0x020 concurrent with burst at 0x200 -> wr0 one cycle later with exact values; burst beat count unchanged.
- Macro defined, burst len=4 at 0x040 and ALU write to 0x042 timed to coincide with the beat -> beat held 1 cycle, wr_collision=1, beat reissued next cycle, burst_done one cycle late. Macro undefined -> no hold, wr_collision=0.
- rst asserted during the second beat of a 16-dword burst -> all outputs 0 immediately; after release req_ready=1, no further wr1 beats.
